// File: rtl/adder_core.sv
// Registered WIDTH-bit adder/subtractor with carry (not-borrow) and signed-overflow flags.
// Define ADDER_SAT_EN to saturate unsigned results instead of wrapping modulo 2^WIDTH.
module adder_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   full_sum;
    logic [WIDTH-1:0] raw_result;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;
    logic             next_overflow;

    // Subtraction is A + ~B + 1, so the top bit of the sum is the not-borrow flag.
    always_comb begin
        operand_b     = sub ? ~data_in2 : data_in2;
        full_sum      = {1'b0, data_in1} + {1'b0, operand_b} + {{WIDTH{1'b0}}, sub};
        raw_result    = full_sum[WIDTH-1:0];
        next_carry    = full_sum[WIDTH];
        next_overflow = 1'b0;
        if (sub) begin
            next_overflow = (data_in1[WIDTH-1] != data_in2[WIDTH-1]) &&
                            (raw_result[WIDTH-1] != data_in1[WIDTH-1]);
        end else begin
            next_overflow = (data_in1[WIDTH-1] == data_in2[WIDTH-1]) &&
                            (raw_result[WIDTH-1] != data_in1[WIDTH-1]);
        end
    end

`ifdef ADDER_SAT_EN
    // Unsigned saturation only; the flags still describe the unsaturated operation.
    always_comb begin
        next_result = raw_result;
        if (!sub && next_carry) begin
            next_result = {WIDTH{1'b1}};
        end else if (sub && !next_carry) begin
            next_result = {WIDTH{1'b0}};
        end
    end
`else
    always_comb begin
        next_result = raw_result;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= next_result;
                carry_out <= next_carry;
                overflow  <= next_overflow;
            end
        end
    end

endmodule

// File: tb/tb_adder_core.sv
// Directed-vector self-checking bench for adder_core at WIDTH = 4.
// Expected results follow ADDER_SAT_EN when the bench is compiled with it.
module tb_adder_core;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             sub;
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             overflow;
    logic             out_valid;

    int compare_count = 0;
    int mismatch_count = 0;

    adder_core #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sub       (sub),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_out  (data_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, let the edge sample them, and settle 1 time unit past it.
    task automatic applyStimulus(input logic r, input logic v, input logic s,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        rst      = r;
        in_valid = v;
        sub      = s;
        data_in1 = a;
        data_in2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic runVector(input string tag, input logic r, input logic v, input logic s,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] exp_data, input logic exp_carry,
                             input logic exp_ovf, input logic exp_valid);
        applyStimulus(r, v, s, a, b);
        checkOutput({tag, ".data"},  8'(data_out),  8'(exp_data));
        checkOutput({tag, ".carry"}, 8'(carry_out), 8'(exp_carry));
        checkOutput({tag, ".ovf"},   8'(overflow),  8'(exp_ovf));
        checkOutput({tag, ".valid"}, 8'(out_valid), 8'(exp_valid));
    endtask

    logic [WIDTH-1:0] exp_wrap_add;
    logic [WIDTH-1:0] exp_b2b_first;
    logic [WIDTH-1:0] exp_sub_borrow;
    logic [WIDTH-1:0] exp_add_ff;
    logic [WIDTH-1:0] exp_add_88;

    initial begin
`ifdef ADDER_SAT_EN
        exp_wrap_add   = 4'hF;
        exp_b2b_first  = 4'hF;
        exp_sub_borrow = 4'h0;
        exp_add_ff     = 4'hF;
        exp_add_88     = 4'hF;
`else
        exp_wrap_add   = 4'h0;
        exp_b2b_first  = 4'h2;
        exp_sub_borrow = 4'hE;
        exp_add_ff     = 4'hE;
        exp_add_88     = 4'h0;
`endif
        $display("[TB] starting adder_core directed vectors");

        // Reset held with valid operands present: outputs stay cleared.
        for (int i = 0; i < 5; i++) begin
            runVector("reset_hold", 1'b1, 1'b1, 1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        end

        runVector("wrap_add",    1'b0, 1'b1, 1'b0, 4'hE, 4'h2, exp_wrap_add,  1'b1, 1'b0, 1'b1);
        runVector("b2b_first",   1'b0, 1'b1, 1'b0, 4'd14, 4'd4, exp_b2b_first, 1'b1, 1'b0, 1'b1);
        runVector("b2b_second",  1'b0, 1'b1, 1'b0, 4'd1, 4'd4, 4'd5, 1'b0, 1'b0, 1'b1);
        runVector("signed_ovf",  1'b0, 1'b1, 1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b1);
        runVector("sub_borrow",  1'b0, 1'b1, 1'b1, 4'd3, 4'd5, exp_sub_borrow, 1'b0, 1'b0, 1'b1);
        runVector("sub_plain",   1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0, 1'b1);
        runVector("add_ff",      1'b0, 1'b1, 1'b0, 4'hF, 4'hF, exp_add_ff, 1'b1, 1'b0, 1'b1);
        runVector("add_88",      1'b0, 1'b1, 1'b0, 4'h8, 4'h8, exp_add_88, 1'b1, 1'b1, 1'b1);
        runVector("sub_ovf",     1'b0, 1'b1, 1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b1);

        // Idle cycles with garbage operands: result and flags hold, out_valid drops.
        for (int i = 0; i < 3; i++) begin
            runVector("hold", 1'b0, 1'b0, 1'b0, 4'h3, 4'hA, 4'h7, 1'b1, 1'b1, 1'b0);
        end

        runVector("pre_reset",   1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
        runVector("mid_reset",   1'b1, 1'b1, 1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        runVector("post_idle",   1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        runVector("post_first",  1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/adder_core.md
Name: adder_core

Overview:
- Registered two-operand integer adder/subtractor with carry and signed-overflow flags.
- Sits in datapath pipelines: operands sampled each clock, result presented one cycle later.
- Unsigned wrap-around arithmetic by default; optional saturation compiled in by macro.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..64).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on rising clk.
- in_valid  input  1  operands valid this cycle.
- sub  input  1  0 = data_in1 + data_in2; 1 = data_in1 - data_in2.
- data_in1  input  WIDTH  operand A.
- data_in2  input  WIDTH  operand B.
- data_out  output  WIDTH  registered result.
- carry_out  output  1  registered carry (add) or not-borrow (sub) from bit WIDTH.
- overflow  output  1  registered two's-complement signed overflow.
- out_valid  output  1  registered copy of in_valid; qualifies data_out and flags.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high: when rst = 1 at a rising clk edge, data_out = 0, carry_out = 0, overflow = 0, out_valid = 0. Reset overrides any in_valid in the same cycle.
- Latency: exactly 1 cycle. Operands and sub sampled at edge N produce data_out and flags from edge N onward.
- Full-width sum:
  - add: {c, r} = A + B, with WIDTH+1-bit intermediate.
  - sub: {c, r} = A + ~B + 1. carry_out = 1 means no borrow (A >= B unsigned).
- data_out = r, truncated modulo 2^WIDTH. Example: 4'hE + 4'h2 gives 0 with carry_out = 1.
- Overflow flag:
  - add: overflow = 1 when A[MSB] == B[MSB] and r[MSB] != A[MSB].
  - sub: overflow = 1 when A[MSB] != B[MSB] and r[MSB] != A[MSB].
- Output update rule:
  - data_out, carry_out and overflow update only on edges where in_valid = 1; otherwise they hold.
  - out_valid updates every edge (= in_valid).
- Back-to-back: a new operand pair every cycle is accepted, giving a sustained throughput of 1 result per cycle. No backpressure.
- Reset mid-stream: the result in flight is discarded. The first valid operand after rst deasserts produces a result 1 cycle later.
- Logic is purely synchronous: no combinational path from inputs to outputs, no latches.

Optional Feature:
- Macro ADDER_SAT_EN.
- Defined: results saturate instead of wrapping.
  - Unsigned add with carry: data_out = all ones.
  - Unsigned sub with borrow: data_out = 0.
  - carry_out and overflow are still reported exactly as in wrap mode.
  - Signed saturation is not provided.
- Not defined: modulo 2^WIDTH wrap-around as specified in Behaviour. No saturation logic is synthesized.

Test Plan:
- Reset: hold rst = 1 for 5 cycles with in_valid = 1 and A = 4'hF, B = 4'h1 -> data_out = 0, carry_out = 0, overflow = 0, out_valid = 0 throughout. On release, the first result appears 1 cycle after the first valid sample.
- Wrap add (WIDTH = 4): A = 4'b1110, B = 4'b0010, sub = 0 -> next cycle data_out = 4'b0000, carry_out = 1, overflow = 0. With ADDER_SAT_EN: data_out = 4'b1111.
- Back-to-back: cycle 1 A = 14, B = 4; cycle 2 A = 1, B = 4 -> consecutive outputs data_out = 2 (carry 1), then 5 (carry 0), each 1 cycle after its inputs.
- Signed overflow: A = 4'b0111, B = 4'b0001 add -> data_out = 4'b1000, overflow = 1, carry_out = 0.
- Subtract: A = 3, B = 5, sub = 1 -> data_out = 4'b1110, carry_out = 0 (borrow), overflow = 0. With ADDER_SAT_EN: data_out = 0.
- Hold and mid-stream reset: in_valid = 0 for 3 cycles -> data_out holds its last value and out_valid = 0. Then assert rst for 1 cycle while a valid result is pending -> all outputs 0 on the next edge.
